// File: rtl/irq_gen_if.sv
// Register port between the memory stage and irq_gen.
// The master side drives the write/read strobes; irq_gen returns registered read data.
interface irq_gen_if;
    logic        wen;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] rdata;

    modport master (
        output wen,
        output waddr,
        output wdata,
        output raddr,
        input  rdata
    );

    modport slave (
        input  wen,
        input  waddr,
        input  wdata,
        input  raddr,
        output rdata
    );
endinterface

// File: rtl/irq_gen.sv
// Interrupt source block: down-counting timer on bit 0, fifteen external edge sources on bits 15:1.
// Build option IRQ_GEN_SYNC_EN adds two-flop synchronizers on ext_irq (otherwise a single sample flop).
module irq_gen #(
    parameter logic [15:0] RESET_MASK = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [14:0] ext_irq,
    irq_gen_if.slave    bus,
    output logic [15:0] interrupts
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_COUNT  = 2'd1;
    localparam logic [1:0] ADDR_RELOAD = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;

    logic        r_en;
    logic        r_auto;
    logic [31:0] r_count;
    logic [31:0] r_reload;
    logic [15:0] r_mask;
    logic [14:0] r_ext_prev;

    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_reload;
    logic        w_wr_mask;
    logic        w_tick;
    logic        w_fire;
    logic        w_en_nxt;
    logic        w_auto_nxt;
    logic [31:0] w_count_nxt;
    logic [31:0] w_reload_nxt;
    logic [15:0] w_mask_nxt;
    logic [31:0] w_rdata_nxt;
    logic [14:0] w_ext_level;
    logic [14:0] w_ext_rise;
    logic [15:0] w_event;

    // One enabled timer step: decrement, or on zero reload (AUTO) / park at zero (one-shot).
    function automatic logic [31:0] timer_step(
        input logic [31:0] count,
        input logic [31:0] reload,
        input logic        auto_mode
    );
        if (count != 32'd0) begin
            return count - 32'd1;
        end else if (auto_mode) begin
            return reload;
        end else begin
            return 32'd0;
        end
    endfunction

    // Write decode and timer next-state; software writes to CTRL/COUNT override the timer.
    always_comb begin
        w_wr_ctrl    = 1'b0;
        w_wr_count   = 1'b0;
        w_wr_reload  = 1'b0;
        w_wr_mask    = 1'b0;
        if (bus.wen) begin
            case (bus.waddr)
                ADDR_CTRL:   w_wr_ctrl   = 1'b1;
                ADDR_COUNT:  w_wr_count  = 1'b1;
                ADDR_RELOAD: w_wr_reload = 1'b1;
                ADDR_MASK:   w_wr_mask   = 1'b1;
                default:     w_wr_ctrl   = 1'b0;
            endcase
        end else begin
            w_wr_ctrl = 1'b0;
        end

        w_tick = clk_en & r_en;
        w_fire = w_tick & (r_count == 32'd0);

        w_en_nxt     = r_en;
        w_auto_nxt   = r_auto;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_mask_nxt   = r_mask;

        if (w_wr_ctrl) begin
            w_en_nxt   = bus.wdata[0];
            w_auto_nxt = bus.wdata[1];
        end else if (w_wr_count) begin
            w_en_nxt = r_en;
        end else if (w_fire && !r_auto) begin
            w_en_nxt = 1'b0;
        end else begin
            w_en_nxt = r_en;
        end

        if (w_wr_count) begin
            w_count_nxt = bus.wdata;
        end else if (w_wr_ctrl) begin
            w_count_nxt = r_count;
        end else if (w_tick) begin
            w_count_nxt = timer_step(r_count, r_reload, r_auto);
        end else begin
            w_count_nxt = r_count;
        end

        if (w_wr_reload) begin
            w_reload_nxt = bus.wdata;
        end else begin
            w_reload_nxt = r_reload;
        end

        if (w_wr_mask) begin
            w_mask_nxt = bus.wdata[15:0];
        end else begin
            w_mask_nxt = r_mask;
        end
    end

`ifdef IRQ_GEN_SYNC_EN
    logic [14:0] r_sync1;
    logic [14:0] r_sync2;

    // Two-flop synchronizer for the asynchronous request lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 15'd0;
            r_sync2 <= 15'd0;
        end else begin
            r_sync1 <= ext_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ext_level = r_sync2;
`else
    logic [14:0] r_samp;

    // Single sample flop; ext_irq is assumed synchronous to clk in this build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp <= 15'd0;
        end else begin
            r_samp <= ext_irq;
        end
    end

    assign w_ext_level = r_samp;
`endif

    assign w_ext_rise = w_ext_level & ~r_ext_prev;
    assign w_event    = {w_ext_rise, w_fire};

    // Read mux over pre-edge register values; unused bits read as zero.
    always_comb begin
        w_rdata_nxt = 32'd0;
        case (bus.raddr)
            ADDR_CTRL:   w_rdata_nxt = {30'd0, r_auto, r_en};
            ADDR_COUNT:  w_rdata_nxt = r_count;
            ADDR_RELOAD: w_rdata_nxt = r_reload;
            ADDR_MASK:   w_rdata_nxt = {16'd0, r_mask};
            default:     w_rdata_nxt = 32'd0;
        endcase
    end

    // Software-visible registers and timer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_count  <= 32'd0;
            r_reload <= 32'd0;
            r_mask   <= RESET_MASK;
        end else begin
            r_en     <= w_en_nxt;
            r_auto   <= w_auto_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_mask   <= w_mask_nxt;
        end
    end

    // Edge-detect history, masked event pulses and read data; all run regardless of clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_prev <= 15'd0;
            interrupts <= 16'd0;
            bus.rdata  <= 32'd0;
        end else begin
            r_ext_prev <= w_ext_level;
            interrupts <= w_event & r_mask;
            bus.rdata  <= w_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_irq_gen.sv
// Self-checking bench for irq_gen: register/timer vector table plus external-line sequences.
module tb_irq_gen;

`ifdef IRQ_GEN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_COUNT  = 2'd1;
    localparam logic [1:0] A_RELOAD = 2'd2;
    localparam logic [1:0] A_MASK   = 2'd3;

    typedef struct {
        logic        wen;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic        clk_en;
        logic [31:0] exp_rdata;
        logic [15:0] exp_irq;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [14:0] ext_irq;
    logic [15:0] interrupts;
    int          errors;
    int          checks;
    vec_t        vecs[$];

    irq_gen_if bus ();

    irq_gen #(.RESET_MASK(16'hFFFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .ext_irq    (ext_irq),
        .bus        (bus.slave),
        .interrupts (interrupts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic wen, input logic [1:0] waddr, input logic [31:0] wdata,
                                input logic [1:0] raddr, input logic ce,
                                input logic [31:0] exp_rd, input logic [15:0] exp_irq);
        vec_t v;
        v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
        v.clk_en = ce; v.exp_rdata = exp_rd; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic wen, input logic [1:0] waddr, input logic [31:0] wdata,
                       input logic [1:0] raddr, input logic ce);
        bus.wen   = wen;
        bus.waddr = waddr;
        bus.wdata = wdata;
        bus.raddr = raddr;
        clk_en    = ce;
        @(posedge clk);
        #1;
    endtask

    // Idle n cycles, expecting exp_bits on exactly the LAT+1-th edge and zero elsewhere.
    task automatic run_ext(input string name, input logic [15:0] exp_bits, input int n);
        for (int j = 1; j <= n; j++) begin
            cyc(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1);
            check32($sformatf("%s cyc%0d", name, j), {16'd0, interrupts},
                    {16'd0, (j == LAT + 1) ? exp_bits : 16'd0});
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        clk_en    = 1'b0;
        ext_irq   = 15'd0;
        bus.wen   = 1'b0;
        bus.waddr = 2'd0;
        bus.wdata = 32'd0;
        bus.raddr = A_MASK;

        repeat (3) @(posedge clk);
        #1;
        check32("reset interrupts", {16'd0, interrupts}, 32'd0);
        check32("reset rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;

        // wen, waddr, wdata, raddr, clk_en, expected rdata, expected interrupts
        add(1'b0, A_CTRL,   32'd0, A_MASK,   1'b1, 32'h0000_FFFF, 16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_CTRL,   1'b1, 32'd0,   16'h0000);
        add(1'b1, A_COUNT,  32'd3, A_COUNT,  1'b1, 32'd0,   16'h0000);
        add(1'b1, A_RELOAD, 32'd3, A_COUNT,  1'b1, 32'd3,   16'h0000);
        add(1'b1, A_CTRL,   32'd3, A_RELOAD, 1'b1, 32'd3,   16'h0000);
        for (int p = 0; p < 4; p++) begin
            add(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1, 32'd3, 16'h0000);
            add(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1, 32'd2, 16'h0000);
            add(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1, 32'd1, 16'h0000);
            add(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1, 32'd0, 16'h0001);
        end
        add(1'b1, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd3,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd3,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_CTRL,   1'b1, 32'd0,   16'h0000);
        // one-shot with clk_en gating
        add(1'b1, A_COUNT,  32'd2, A_COUNT,  1'b1, 32'd3,   16'h0000);
        add(1'b1, A_CTRL,   32'd1, A_COUNT,  1'b1, 32'd2,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd2,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b0, 32'd1,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd1,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b0, 32'd0,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd0,   16'h0001);
        add(1'b0, A_CTRL,   32'd0, A_CTRL,   1'b1, 32'd0,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd0,   16'h0000);
        // write collision on the firing edge
        add(1'b1, A_CTRL,   32'd1, A_COUNT,  1'b1, 32'd0,   16'h0000);
        add(1'b1, A_COUNT,  32'd100, A_COUNT, 1'b1, 32'd0,  16'h0001);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b0, 32'd100, 16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd100, 16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b0, 32'd99,  16'h0000);
        add(1'b1, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd99,  16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_COUNT,  1'b1, 32'd99,  16'h0000);
        // reserved bits
        add(1'b1, A_CTRL,   32'hFFFF_FFFC, A_CTRL, 1'b1, 32'd0, 16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_CTRL,   1'b1, 32'd0,   16'h0000);
        add(1'b1, A_MASK,   32'h1234_5678, A_MASK, 1'b1, 32'h0000_FFFF, 16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_MASK,   1'b1, 32'h0000_5678, 16'h0000);
        // masked timer event is dropped, not deferred
        add(1'b1, A_MASK,   32'h0000_FFFE, A_MASK, 1'b1, 32'h0000_5678, 16'h0000);
        add(1'b1, A_COUNT,  32'd0, A_MASK,   1'b1, 32'h0000_FFFE, 16'h0000);
        add(1'b1, A_CTRL,   32'd1, A_COUNT,  1'b1, 32'd0,   16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_CTRL,   1'b1, 32'd1,   16'h0000);
        add(1'b1, A_MASK,   32'h0000_FFFF, A_CTRL, 1'b1, 32'd0, 16'h0000);
        add(1'b0, A_CTRL,   32'd0, A_MASK,   1'b1, 32'h0000_FFFF, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr, vecs[i].clk_en);
            check32($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
            check32($sformatf("vec%0d interrupts", i), {16'd0, interrupts}, {16'd0, vecs[i].exp_irq});
        end

        // ext_irq[4] held high: one pulse on bit 5, nothing while held or on the fall
        ext_irq[4] = 1'b1;
        run_ext("ext5 rise", 16'h0020, 10);
        ext_irq[4] = 1'b0;
        run_ext("ext5 fall", 16'h0000, 4);

        // mask blocks bit 1, later re-rise fires
        cyc(1'b1, A_MASK, 32'h0000_0001, A_MASK, 1'b1);
        check32("mask write irq", {16'd0, interrupts}, 32'd0);
        ext_irq[0] = 1'b1;
        run_ext("ext1 masked", 16'h0000, 6);
        cyc(1'b1, A_MASK, 32'h0000_FFFF, A_MASK, 1'b1);
        check32("unmask irq", {16'd0, interrupts}, 32'd0);
        ext_irq[0] = 1'b0;
        run_ext("ext1 drop", 16'h0000, 4);
        ext_irq[0] = 1'b1;
        run_ext("ext1 refire", 16'h0002, 6);
        ext_irq[0] = 1'b0;
        run_ext("ext1 idle", 16'h0000, 4);

        // all lines at once
        ext_irq = 15'h7FFF;
        run_ext("ext all", 16'hFFFE, 6);
        ext_irq = 15'd0;
        run_ext("ext all fall", 16'h0000, 4);

        // reset mid-count with a line already high
        cyc(1'b1, A_COUNT, 32'd5, A_COUNT, 1'b1);
        cyc(1'b1, A_CTRL, 32'd1, A_COUNT, 1'b1);
        cyc(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1);
        cyc(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1);
        check32("pre-reset count", bus.rdata, 32'd4);
        bus.wen    = 1'b0;
        ext_irq[2] = 1'b1;
        rst_n      = 1'b0;
        #1;
        check32("async reset rdata", bus.rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check32("mid reset interrupts", {16'd0, interrupts}, 32'd0);
        rst_n = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc(1'b0, A_CTRL, 32'd0, A_COUNT, 1'b1);
            check32($sformatf("post reset irq cyc%0d", j), {16'd0, interrupts},
                    {16'd0, (j == LAT + 1) ? 16'h0008 : 16'h0000});
            check32($sformatf("post reset count cyc%0d", j), bus.rdata, 32'd0);
        end
        cyc(1'b0, A_CTRL, 32'd0, A_CTRL, 1'b1);
        check32("post reset ctrl", bus.rdata, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_gen.md
# irq_gen

Interrupt source block for the Dioptase pipeline. It produces the 16-bit `interrupts` vector that the control register file ORs into its pending-interrupt register. Sources are a programmable down-counting timer on bit 0 and fifteen asynchronous external request lines on bits 15:1. Every source is reduced to a one-cycle registered pulse, gated by a software mask. Software programs the block through a small 4-word register port driven by the memory stage.

## Interface

Parameters:
- `RESET_MASK`, default `16'hFFFF`: reset value of the MASK register.

Ports:
- `clk`  in  1  clock; every flop in the block is clocked on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clk_en`  in  1  pipeline clock enable; gates timer counting only.
- `ext_irq`  in  15  external requests for bits 15:1; asynchronous; a rising level is the event.
- `wen`  in  1  register write strobe.
- `waddr`  in  2  write address: 0=CTRL, 1=COUNT, 2=RELOAD, 3=MASK.
- `wdata`  in  32  write data.
- `raddr`  in  2  read address, same register map as `waddr`.
- `rdata`  out  32  registered read data.
- `interrupts`  out  16  registered one-cycle event pulses, connected to the cregfile `interrupts` input.

## Operation

Registers:
- CTRL: bit0 EN, bit1 AUTO. Bits 31:2 read as 0 and ignore writes.
- COUNT: 32-bit down counter.
- RELOAD: 32-bit reload value.
- MASK: bits 15:0 are the per-bit output enables. Bits 31:16 read as 0.

Timer, evaluated on each edge where `clk_en`=1 and EN=1:
- COUNT≠0: COUNT <= COUNT−1.
- COUNT==0: raise the bit-0 event. If AUTO=1, COUNT <= RELOAD. If AUTO=0, EN <= 0 and COUNT stays 0.
- Result: with AUTO=1 the period is RELOAD+1 enabled cycles. RELOAD=0 fires on every enabled cycle.
- `clk_en`=0: COUNT and EN hold.

Write collisions:
- A software write to COUNT or CTRL in the same cycle as a timer update wins outright; the timer update for that cycle is discarded.
- If that timer update was a firing tick, its bit-0 event is still raised.

External lines, per bit i in 15:1:
- Two-flop synchronizer, then edge detect against the previous synchronized value.
- A rising edge raises event i.
- Held-high lines and falling edges produce nothing.

Output:
- `interrupts[i] <= event[i] & MASK[i]` on every edge, independent of `clk_en`.
- Masked events are dropped, not deferred.
- A line that rises again re-fires; there is no coalescing state beyond the single-cycle pulse.

Reads:
- `rdata <= reg[raddr]` on every edge.
- COUNT returns its pre-edge value.

Reset (`rst_n` low):
- CTRL, COUNT, RELOAD → 0.
- MASK → `RESET_MASK`.
- `interrupts` → 0, `rdata` → 0.
- Synchronizer and edge-detect flops → 0. A line already high when reset releases therefore fires once after the synchronizer fills.
- Reset asserted mid-count clears the timer immediately. No pulse is emitted for the interrupted count.

## Timing

- External latency: `ext_irq[i]` rises before edge k → `interrupts[i]` is high from edge k+2 to edge k+3, exactly one cycle.
- Timer latency: the edge that observes COUNT==0 with EN=1 and `clk_en`=1 drives `interrupts[0]` high for the following cycle.
- Write-to-read: a write at edge k is visible in `rdata` after edge k+1, provided `raddr` selects that register during the cycle after edge k.
- MASK write: takes effect for the events evaluated on the edge after the write edge.
- Multiple bits may pulse in the same cycle; there is no priority among sources.

## Configuration

- `IRQ_GEN_SYNC_EN` defined: the two-flop synchronizers are present, giving the external latency stated above.
- `IRQ_GEN_SYNC_EN` undefined: `ext_irq` must be synchronous to `clk`. There is a single sample flop feeding the edge detect, and external latency drops by one cycle: rising before edge k → pulse from edge k+1.
- Timer behaviour and the register map are identical in both builds.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles → `interrupts`=0, `rdata`=0, MASK reads 0xFFFF.
- Auto-reload timer: write RELOAD=3, COUNT=3, CTRL=3 with `clk_en`=1 → `interrupts[0]` pulses every 4 cycles; 4 pulses in 16 cycles.
- One-shot timer with `clk_en` gating:
  - Write COUNT=2, CTRL=1 (AUTO=0) and toggle `clk_en` 1,0,1,0,1 → exactly one pulse, on the 3rd enabled edge.
  - CTRL then reads 0.
- External edge latency and level hold: raise `ext_irq[4]` (bit 5) and hold it high for 10 cycles → exactly one pulse on `interrupts[5]`, 2 edges later with `IRQ_GEN_SYNC_EN`, 1 edge later without.
- Mask:
  - Write MASK=0x0001, then raise `ext_irq[0]` (bit 1) → no pulse.
  - Write MASK=0xFFFF, drop the line, raise it again → one pulse on `interrupts[1]`.
- Collision:
  - With COUNT=0 and EN=1, write COUNT=100 on the firing edge → bit-0 pulse still emitted.
  - COUNT then reads 100, then 99 on the following enabled edge.
